alu_reservation_station: RTL and testbench

//  Receiving end of the dispatch->RS interface. Holds renamed ALU instructions until both source

---
 rtl/alu_reservation_station.sv | 171 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers renamed ALU ops until both sources are ready, issues one per cycle.
// Build option RS_AGE_SELECT_EN: oldest-first select via an age matrix (default: lowest-index select).
// Instruction vector layout, LSB first: alu_op, alu_src, imm, rob_tag, prd, prs2, prs1.
module alu_reservation_station #(
   parameter int DEPTH      = 8,
   parameter int PREG_BITS  = 7,
   parameter int ROB_BITS   = 6,
   parameter int IMM_BITS   = 32,
   parameter int OP_BITS    = 4,
   localparam int INSTR_BITS = OP_BITS + 1 + IMM_BITS + ROB_BITS + 3 * PREG_BITS,
   localparam int CNT_BITS   = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dispatch_en,
   input  logic [INSTR_BITS-1:0] dispatch_instr,
   input  logic                  src1_rdy_in,
   input  logic                  src2_rdy_in,
   output logic                  rs_full,
   output logic [CNT_BITS-1:0]   rs_count,
   input  logic                  cdb_valid,
   input  logic [PREG_BITS-1:0]  cdb_tag,
   output logic                  issue_valid,
   output logic [INSTR_BITS-1:0] issue_instr,
   input  logic                  issue_ready,
   input  logic                  flush
);

   localparam int IDX_BITS    = $clog2(DEPTH);
   localparam int ALU_SRC_POS = OP_BITS;
   localparam int PRS2_LSB    = OP_BITS + 1 + IMM_BITS + ROB_BITS + PREG_BITS;
   localparam int PRS1_LSB    = PRS2_LSB + PREG_BITS;

   logic [DEPTH-1:0]      valid_reg;
   logic [DEPTH-1:0]      rdy1_reg;
   logic [DEPTH-1:0]      rdy2_reg;
   logic [INSTR_BITS-1:0] instr_reg [DEPTH];
   logic [CNT_BITS-1:0]   count_reg;

   logic [DEPTH-1:0]      cand;
   logic [DEPTH-1:0]      pick;
   logic [DEPTH-1:0]      wake1;
   logic [DEPTH-1:0]      wake2;
   logic [DEPTH-1:0]      alloc_oh;
   logic [DEPTH-1:0]      alloc_w;
   logic [DEPTH-1:0]      sel_oh;
   logic [DEPTH-1:0]      free_w;
   logic [IDX_BITS-1:0]   sel_idx;
   logic                  sel_found;
   logic                  alloc_found;
   logic                  dispatch_fire;
   logic                  issue_fire;
   logic                  disp_rdy1;
   logic                  disp_rdy2;
   logic [DEPTH-1:0]      valid_next;
   logic [DEPTH-1:0]      rdy1_next;
   logic [DEPTH-1:0]      rdy2_next;

   assign rs_full       = (count_reg == CNT_BITS'(DEPTH));
   assign rs_count      = count_reg;
   assign dispatch_fire = dispatch_en & ~rs_full & ~flush;
   assign issue_valid   = |cand;
   assign issue_fire    = issue_valid & issue_ready;
   assign issue_instr   = issue_valid ? instr_reg[sel_idx] : '0;

   // A same-cycle broadcast of a source tag counts as ready at capture time.
   assign disp_rdy1 = src1_rdy_in |
                      (cdb_valid && cdb_tag == dispatch_instr[PRS1_LSB +: PREG_BITS]);
   assign disp_rdy2 = src2_rdy_in | dispatch_instr[ALU_SRC_POS] |
                      (cdb_valid && cdb_tag == dispatch_instr[PRS2_LSB +: PREG_BITS]);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign cand[gi]  = valid_reg[gi] & rdy1_reg[gi] & rdy2_reg[gi];
         assign wake1[gi] = valid_reg[gi] & cdb_valid &
                            (cdb_tag == instr_reg[gi][PRS1_LSB +: PREG_BITS]);
         assign wake2[gi] = valid_reg[gi] & cdb_valid &
                            (cdb_tag == instr_reg[gi][PRS2_LSB +: PREG_BITS]);
      end
   endgenerate

   // Lowest-index free entry; rs_full guarantees one exists whenever dispatch fires.
   always_comb begin
      alloc_oh    = '0;
      alloc_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_reg[i] && !alloc_found) begin
            alloc_oh[i] = 1'b1;
            alloc_found = 1'b1;
         end
      end
   end

   assign alloc_w = dispatch_fire ? alloc_oh : '0;

`ifdef RS_AGE_SELECT_EN
   // older_reg[i][j] = 1 means entry i was dispatched before entry j.
   logic [DEPTH-1:0] older_reg [DEPTH];
   logic [DEPTH-1:0] blocked;

   always_comb begin
      blocked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            blocked[i] = blocked[i] | (cand[j] & older_reg[j][i]);
         end
      end
   end

   assign pick = cand & ~blocked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
      end else if (dispatch_fire) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i])
               older_reg[i] <= '0;
            else if (valid_reg[i])
               older_reg[i] <= older_reg[i] | alloc_oh;
         end
      end
   end
`else
   assign pick = cand;
`endif

   always_comb begin
      sel_idx   = '0;
      sel_oh    = '0;
      sel_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pick[i] && !sel_found) begin
            sel_idx   = IDX_BITS'(i);
            sel_oh[i] = 1'b1;
            sel_found = 1'b1;
         end
      end
   end

   assign free_w     = issue_fire ? sel_oh : '0;
   assign valid_next = (valid_reg & ~free_w) | alloc_w;
   assign rdy1_next  = ((rdy1_reg | wake1) & ~alloc_w) | (alloc_w & {DEPTH{disp_rdy1}});
   assign rdy2_next  = ((rdy2_reg | wake2) & ~alloc_w) | (alloc_w & {DEPTH{disp_rdy2}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         rdy1_reg  <= '0;
         rdy2_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         valid_reg <= '0;
         count_reg <= '0;
      end else begin
         valid_reg <= valid_next;
         rdy1_reg  <= rdy1_next;
         rdy2_reg  <= rdy2_next;
         count_reg <= count_reg + CNT_BITS'(dispatch_fire) - CNT_BITS'(issue_fire);
      end
   end

   // Payload storage needs no reset: it is only observed through a valid entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_w[i]) instr_reg[i] <= dispatch_instr;
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus a randomized run
// checked against a slot-array reference model.
module tb_alu_reservation_station;

   localparam int DEPTH = 8;
   localparam int IW    = 64;

   logic          clk;
   logic          rst_n;
   logic          dispatch_en;
   logic [IW-1:0] dispatch_instr;
   logic          src1_rdy_in;
   logic          src2_rdy_in;
   logic          rs_full;
   logic [3:0]    rs_count;
   logic          cdb_valid;
   logic [6:0]    cdb_tag;
   logic          issue_valid;
   logic [IW-1:0] issue_instr;
   logic          issue_ready;
   logic          flush;

   int total = 0;
   int bad   = 0;

   alu_reservation_station dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dispatch_en    (dispatch_en),
      .dispatch_instr (dispatch_instr),
      .src1_rdy_in    (src1_rdy_in),
      .src2_rdy_in    (src2_rdy_in),
      .rs_full        (rs_full),
      .rs_count       (rs_count),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .issue_valid    (issue_valid),
      .issue_instr    (issue_instr),
      .issue_ready    (issue_ready),
      .flush          (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one record per slot, age kept as a dispatch sequence number.
   typedef struct {
      bit            v;
      bit            r1;
      bit            r2;
      logic [IW-1:0] ins;
      int            seq;
   } ent_t;

   ent_t m [DEPTH];
   int   seq_ctr;

   function automatic logic [IW-1:0] mk(input int p1, input int p2, input int rob, input bit asrc);
      logic [IW-1:0] v;
      v        = '0;
      v[3:0]   = 4'($urandom);
      v[4]     = asrc;
      v[36:5]  = $urandom;
      v[42:37] = 6'(rob);
      v[49:43] = 7'($urandom);
      v[56:50] = 7'(p2);
      v[63:57] = 7'(p1);
      return v;
   endfunction

   function automatic int m_sel();
      int best;
      best = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_SELECT_EN
            if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   function automatic int m_cnt();
      int c;
      c = 0;
      for (int i = 0; i < DEPTH; i++) if (m[i].v) c++;
      return c;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m[i].v = 0; m[i].r1 = 0; m[i].r2 = 0; m[i].ins = '0; m[i].seq = 0;
      end
      seq_ctr = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic m_step();
      int s, c, slot;
      s = m_sel();
      c = m_cnt();
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) m[i].v = 0;
         return;
      end
      slot = -1;
      if (dispatch_en && c < DEPTH)
         for (int i = 0; i < DEPTH; i++) if (!m[i].v && slot < 0) slot = i;
      if (cdb_valid)
         for (int i = 0; i < DEPTH; i++) if (m[i].v) begin
            if (m[i].ins[63:57] == cdb_tag) m[i].r1 = 1;
            if (m[i].ins[56:50] == cdb_tag) m[i].r2 = 1;
         end
      if (s >= 0 && issue_ready) m[s].v = 0;
      if (slot >= 0) begin
         m[slot].v   = 1;
         m[slot].ins = dispatch_instr;
         m[slot].r1  = src1_rdy_in || (cdb_valid && dispatch_instr[63:57] == cdb_tag);
         m[slot].r2  = src2_rdy_in || dispatch_instr[4] || (cdb_valid && dispatch_instr[56:50] == cdb_tag);
         m[slot].seq = seq_ctr;
         seq_ctr++;
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      dispatch_en = 0; dispatch_instr = '0; src1_rdy_in = 0; src2_rdy_in = 0;
      cdb_valid = 0; cdb_tag = '0; issue_ready = 0; flush = 0;
   endtask

   task automatic do_flush();
      flush = 1; tick(); flush = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      m_reset();
      @(negedge clk); @(negedge clk);
      total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", rs_full); end
      total++; if (rs_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", rs_count); end
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_iv got=%0b want=0", issue_valid); end
      total++; if (issue_instr !== '0) begin bad++; $display("FAIL reset_instr got=%0h want=0", issue_instr); end
      rst_n = 1;
      tick(); tick();
      total++; if (rs_count !== 4'd0 || rs_full !== 1'b0 || issue_valid !== 1'b0) begin
         bad++; $display("FAIL reset_idle got cnt=%0d full=%0b iv=%0b want 0/0/0", rs_count, rs_full, issue_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_ready_dispatch();
      dispatch_en = 1; dispatch_instr = mk(1, 2, 3, 0); src1_rdy_in = 1; src2_rdy_in = 1; issue_ready = 1;
      tick();
      dispatch_en = 0;
      total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL ready_iv got=%0b want=1", issue_valid); end
      total++; if (issue_instr[42:37] !== 6'd3) begin bad++; $display("FAIL ready_rob got=%0d want=3", issue_instr[42:37]); end
      $display("issue rob=%0d", issue_instr[42:37]);
      tick();
      total++; if (rs_count !== 4'd0) begin bad++; $display("FAIL ready_cnt got=%0d want=0", rs_count); end
      idle_inputs();
   endtask

   task automatic test_wakeup();
      issue_ready = 1;
      dispatch_en = 1; dispatch_instr = mk(40, 5, 11, 0); src1_rdy_in = 0; src2_rdy_in = 1;
      tick();
      dispatch_en = 0;
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_early1 got=%0b want=0", issue_valid); end
      tick();
      cdb_valid = 1; cdb_tag = 7'd40;
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_bcast got=%0b want=0", issue_valid); end
      tick();
      cdb_valid = 0;
      total++; if (issue_valid !== 1'b1 || issue_instr[42:37] !== 6'd11) begin
         bad++; $display("FAIL wake_issue got iv=%0b rob=%0d want 1/11", issue_valid, issue_instr[42:37]);
      end
      tick();
      // Broadcast of prs2 in the dispatch cycle must be captured.
      dispatch_en = 1; dispatch_instr = mk(10, 41, 12, 0); src1_rdy_in = 1; src2_rdy_in = 0;
      cdb_valid = 1; cdb_tag = 7'd41;
      tick();
      dispatch_en = 0; cdb_valid = 0;
      total++; if (issue_valid !== 1'b1 || issue_instr[42:37] !== 6'd12) begin
         bad++; $display("FAIL wake_capture got iv=%0b rob=%0d want 1/12", issue_valid, issue_instr[42:37]);
      end
      tick();
      total++; if (rs_count !== 4'd0) begin bad++; $display("FAIL wake_cnt got=%0d want=0", rs_count); end
      idle_inputs();
   endtask

   task automatic test_full();
      issue_ready = 0;
      for (int i = 0; i < DEPTH; i++) begin
         dispatch_en = 1; dispatch_instr = mk(20 + i, 60 + i, 16 + i, 0); src1_rdy_in = 0; src2_rdy_in = 0;
         tick();
      end
      dispatch_en = 0;
      total++; if (rs_count !== 4'd8 || rs_full !== 1'b1) begin
         bad++; $display("FAIL full_set got cnt=%0d full=%0b want 8/1", rs_count, rs_full);
      end
      cdb_valid = 1; cdb_tag = 7'd20; tick();
      cdb_tag = 7'd60; tick();
      cdb_valid = 0;
      total++; if (issue_valid !== 1'b1 || issue_instr[42:37] !== 6'd16) begin
         bad++; $display("FAIL full_wake got iv=%0b rob=%0d want 1/16", issue_valid, issue_instr[42:37]);
      end
      issue_ready = 1;
      total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_hold got=%0b want=1", rs_full); end
      tick();
      issue_ready = 0;
      total++; if (rs_full !== 1'b0 || rs_count !== 4'd7) begin
         bad++; $display("FAIL full_free got cnt=%0d full=%0b want 7/0", rs_count, rs_full);
      end
      cdb_valid = 1; cdb_tag = 7'd21; tick();
      cdb_tag = 7'd61; tick();
      cdb_valid = 0;
      dispatch_en = 1; dispatch_instr = mk(1, 2, 50, 0); src1_rdy_in = 1; src2_rdy_in = 1; issue_ready = 1;
      tick();
      dispatch_en = 0; issue_ready = 0;
      total++; if (rs_count !== 4'd7) begin bad++; $display("FAIL full_both got=%0d want=7", rs_count); end
      do_flush();
      total++; if (rs_count !== 4'd0) begin bad++; $display("FAIL full_clear got=%0d want=0", rs_count); end
      idle_inputs();
   endtask

   task automatic test_flush();
      issue_ready = 0;
      for (int i = 0; i < 5; i++) begin
         dispatch_en = 1; dispatch_instr = mk(100 + i, 110 + i, 24 + i, 0);
         src1_rdy_in = (i < 2); src2_rdy_in = (i < 2);
         tick();
      end
      total++; if (rs_count !== 4'd5 || issue_valid !== 1'b1) begin
         bad++; $display("FAIL flush_pre got cnt=%0d iv=%0b want 5/1", rs_count, issue_valid);
      end
      flush = 1; dispatch_en = 1; dispatch_instr = mk(1, 2, 33, 0); src1_rdy_in = 1; src2_rdy_in = 1;
      total++; if (issue_valid !== 1'b1 || rs_count !== 4'd5) begin
         bad++; $display("FAIL flush_cycle got iv=%0b cnt=%0d want 1/5", issue_valid, rs_count);
      end
      tick();
      flush = 0; dispatch_en = 0;
      total++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin
         bad++; $display("FAIL flush_after got cnt=%0d iv=%0b want 0/0", rs_count, issue_valid);
      end
      tick();
      total++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin
         bad++; $display("FAIL flush_drop got cnt=%0d iv=%0b want 0/0", rs_count, issue_valid);
      end
      idle_inputs();
   endtask

   task automatic test_select_order();
      logic [5:0] first, second;
`ifdef RS_AGE_SELECT_EN
      first = 6'd7; second = 6'd9;
`else
      first = 6'd9; second = 6'd7;
`endif
      issue_ready = 0;
      dispatch_en = 1; dispatch_instr = mk(1, 2, 1, 0); src1_rdy_in = 1; src2_rdy_in = 1; tick();
      dispatch_instr = mk(30, 31, 2, 0); src1_rdy_in = 0; src2_rdy_in = 0; tick();
      dispatch_instr = mk(35, 3, 7, 0); src1_rdy_in = 0; src2_rdy_in = 1; tick();
      dispatch_en = 0;
      total++; if (issue_instr[42:37] !== 6'd1) begin bad++; $display("FAIL order_e0 got=%0d want=1", issue_instr[42:37]); end
      issue_ready = 1; tick(); issue_ready = 0;
      dispatch_en = 1; dispatch_instr = mk(35, 4, 9, 0); src1_rdy_in = 0; src2_rdy_in = 1; tick();
      dispatch_en = 0;
      cdb_valid = 1; cdb_tag = 7'd35; tick();
      cdb_valid = 0;
      total++; if (issue_valid !== 1'b1 || issue_instr[42:37] !== first) begin
         bad++; $display("FAIL order_first got iv=%0b rob=%0d want 1/%0d", issue_valid, issue_instr[42:37], first);
      end
      issue_ready = 1; tick(); issue_ready = 0;
      total++; if (issue_valid !== 1'b1 || issue_instr[42:37] !== second) begin
         bad++; $display("FAIL order_second got iv=%0b rob=%0d want 1/%0d", issue_valid, issue_instr[42:37], second);
      end
      do_flush();
      idle_inputs();
   endtask

   task automatic test_random();
      int es, ec;
      logic [IW-1:0] ei;
      for (int n = 0; n < 600; n++) begin
         es = m_sel();
         ec = m_cnt();
         ei = (es >= 0) ? m[es].ins : '0;
         total++; if (issue_valid !== (es >= 0)) begin bad++; $display("FAIL rnd_iv n=%0d got=%0b want=%0b", n, issue_valid, es >= 0); end
         total++; if (issue_instr !== ei) begin bad++; $display("FAIL rnd_instr n=%0d got=%0h want=%0h", n, issue_instr, ei); end
         total++; if (rs_count !== 4'(ec)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, rs_count, ec); end
         total++; if (rs_full !== (ec == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got=%0b want=%0b", n, rs_full, ec == DEPTH); end
         dispatch_en    = ($urandom_range(0, 2) != 0) && (ec < DEPTH);
         dispatch_instr = mk($urandom_range(0, 15), $urandom_range(0, 15), n % 64, $urandom_range(0, 3) == 0);
         src1_rdy_in    = $urandom_range(0, 9) < 4;
         src2_rdy_in    = $urandom_range(0, 9) < 4;
         cdb_valid      = $urandom_range(0, 1) != 0;
         cdb_tag        = 7'($urandom_range(0, 15));
         issue_ready    = $urandom_range(0, 9) < 6;
         flush          = $urandom_range(0, 49) == 0;
         if (issue_valid && issue_ready && !flush) $display("issue rob=%0d", issue_instr[42:37]);
         tick();
      end
      idle_inputs();
      // Asynchronous reset in mid-operation, with entries loaded.
      for (int i = 0; i < 3; i++) begin
         dispatch_en = 1; dispatch_instr = mk(1, 2, 40 + i, 0); src1_rdy_in = 1; src2_rdy_in = 1; tick();
      end
      dispatch_en = 0;
      #2 rst_n = 0;
      #1;
      total++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin
         bad++; $display("FAIL async_rst got cnt=%0d iv=%0b want 0/0", rs_count, issue_valid);
      end
      m_reset();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      test_reset();
      test_ready_dispatch();
      test_wakeup();
      test_full();
      test_flush();
      test_select_order();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
